// File: rtl/seq_pkg.sv
// Shared definitions for the bytecode decode sequencer: state encoding,
// prefix opcodes and the operand-count width helper.
package seq_pkg;

    localparam logic [1:0] FETCH_OP     = 2'd0;
    localparam logic [1:0] FETCH_PARAMS = 2'd1;
    localparam logic [1:0] ITERATE      = 2'd2;

    localparam logic [7:0] WIDE_OPCODE_DEF = 8'hC4;
    localparam logic [7:0] NOP_OPCODE_DEF  = 8'h00;

    // Bits needed to hold a byte count in the range 0..max_bytes.
    function automatic int unsigned cnt_w(input int unsigned max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/opnd_collector.sv
// Operand byte buffer: writes one byte at a given index, clears all bytes on request.
module opnd_collector #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned IW     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_i,
    input  logic                  wr_i,
    input  logic [IW-1:0]         idx_i,
    input  logic [7:0]            data_i,
    output logic [8*NBYTES-1:0]   bytes_o
);

    logic [8*NBYTES-1:0] bytes_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bytes_q <= '0;
        end else if (clr_i) begin
            bytes_q <= '0;
        end else if (wr_i) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (idx_i == IW'(i)) begin
                    bytes_q[8*i +: 8] <= data_i;
                end
            end
        end
    end

    assign bytes_o = bytes_q;

endmodule

// File: rtl/bytecode_sequencer.sv
// Bytecode front-end decode sequencer: fetches opcode (with WIDE prefix) and
// operands over a byte handshake, then walks the microcode address chain.
module bytecode_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADR_W          = 8,
    parameter int unsigned PARAM_LEN      = 3,
    parameter int unsigned MAX_OPND_BYTES = 4,
    parameter logic [7:0]  WIDE_OPCODE    = WIDE_OPCODE_DEF,
    parameter logic [7:0]  NOP_OPCODE     = NOP_OPCODE_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ib_valid,
    input  logic [7:0]                        ib_data,
    output logic                              ib_ready,
    input  logic [PARAM_LEN-1:0]              param_count,
    input  logic [ADR_W-1:0]                  useq_next,
    output logic [ADR_W-1:0]                  useq_adr,
    output logic                              useq_valid,
    input  logic                              useq_ready,
    output logic [7:0]                        jvm_opcode,
    output logic [8*MAX_OPND_BYTES-1:0]       operands,
    output logic [cnt_w(MAX_OPND_BYTES)-1:0]  opnd_count,
    output logic                              is_wide,
    output logic                              illegal,
    output logic                              busy
);

    localparam int unsigned CW = cnt_w(MAX_OPND_BYTES);
    localparam int unsigned NW = PARAM_LEN + 1;

    logic [1:0]       state_q,   state_d;
    logic             wide_q,    wide_d;
    logic [7:0]       opcode_q,  opcode_d;
    logic             is_wide_q, is_wide_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [CW-1:0]    idx_q,     idx_d;
    logic [ADR_W-1:0] adr_q,     adr_d;
    logic             illegal_q, illegal_d;

    logic          ib_fire_c;
    logic          useq_fire_c;
    logic [NW-1:0] n_c;
    logic          clr_c;
    logic          wr_c;

    assign ib_ready    = (state_q == FETCH_OP) || (state_q == FETCH_PARAMS);
    assign useq_valid  = (state_q == ITERATE);
    assign ib_fire_c   = ib_valid && ib_ready;
    assign useq_fire_c = useq_valid && useq_ready;
    // One extra bit so the WIDE doubling cannot overflow.
    assign n_c         = NW'(param_count) << wide_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH_OP;
            wide_q    <= 1'b0;
            opcode_q  <= '0;
            is_wide_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            adr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wide_q    <= wide_d;
            opcode_q  <= opcode_d;
            is_wide_q <= is_wide_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            adr_q     <= adr_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wide_d    = wide_q;
        opcode_d  = opcode_q;
        is_wide_d = is_wide_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        adr_d     = adr_q;
        illegal_d = 1'b0;
        clr_c     = 1'b0;
        wr_c      = 1'b0;
        case (state_q)
            FETCH_OP: begin
                if (ib_fire_c) begin
                    if (ib_data == WIDE_OPCODE) begin
                        wide_d = 1'b1;
                    end else if (ib_data != NOP_OPCODE) begin
                        opcode_d  = ib_data;
                        is_wide_d = wide_q;
                        cnt_d     = CW'(n_c);
                        idx_d     = '0;
                        clr_c     = 1'b1;
                        if (32'(n_c) > MAX_OPND_BYTES) begin
                            illegal_d = 1'b1;
                            wide_d    = 1'b0;
                        end else if (n_c == '0) begin
                            state_d = ITERATE;
                            adr_d   = ADR_W'(ib_data);
                        end else begin
                            state_d = FETCH_PARAMS;
                        end
                    end
                end
            end
            FETCH_PARAMS: begin
                if (ib_fire_c) begin
                    wr_c  = 1'b1;
                    idx_d = idx_q + CW'(1);
                    if (idx_q == cnt_q - CW'(1)) begin
                        state_d = ITERATE;
                        adr_d   = ADR_W'(opcode_q);
                    end
                end
            end
            ITERATE: begin
                // is_wide keeps describing the finished opcode until the next latch.
                if (useq_fire_c) begin
                    if (useq_next == '0) begin
                        state_d = FETCH_OP;
                        wide_d  = 1'b0;
                    end else begin
                        adr_d = useq_next;
                    end
                end
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase
    end

    opnd_collector #(
        .NBYTES (MAX_OPND_BYTES),
        .IW     (CW)
    ) u_opnd_collector (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_c),
        .wr_i    (wr_c),
        .idx_i   (idx_q),
        .data_i  (ib_data),
        .bytes_o (operands)
    );

    assign useq_adr   = adr_q;
    assign jvm_opcode = opcode_q;
    assign opnd_count = cnt_q;
    assign is_wide    = is_wide_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q != FETCH_OP) || wide_q;

endmodule

// File: tb/tb_bytecode_sequencer.sv
// Randomized bench for bytecode_sequencer against an instruction-level scoreboard.
module tb_bytecode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ib_valid;
    logic [7:0]  ib_data;
    logic        ib_ready;
    logic [2:0]  param_count;
    logic [7:0]  useq_next;
    logic [7:0]  useq_adr;
    logic        useq_valid;
    logic        useq_ready;
    logic [7:0]  jvm_opcode;
    logic [31:0] operands;
    logic [2:0]  opnd_count;
    logic        is_wide;
    logic        illegal;
    logic        busy;

    logic [2:0] pc_rom [256];
    logic [7:0] nx_rom [256];

    typedef struct {
        logic [7:0]  adr;
        logic [7:0]  opc;
        int          cnt;
        logic [31:0] ops;
        logic        wide;
        bit          last;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_illegal = 0;
    int          seen_illegal = 0;
    int          force_stall = 0;
    bit          mon_en = 1'b0;
    bit          gap_en = 1'b0;
    bit          prev_stall = 1'b0;
    bit          chk_after = 1'b0;
    bit          mwide = 1'b0;
    logic [7:0]  prev_adr = 8'h00;

    always #5 clk = ~clk;

    assign param_count = pc_rom[ib_data];
    assign useq_next   = nx_rom[useq_adr];

    bytecode_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .ib_valid    (ib_valid),
        .ib_data     (ib_data),
        .ib_ready    (ib_ready),
        .param_count (param_count),
        .useq_next   (useq_next),
        .useq_adr    (useq_adr),
        .useq_valid  (useq_valid),
        .useq_ready  (useq_ready),
        .jvm_opcode  (jvm_opcode),
        .operands    (operands),
        .opnd_count  (opnd_count),
        .is_wide     (is_wide),
        .illegal     (illegal),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one byte; returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        if (gap_en) repeat ($urandom_range(0, 3)) @(negedge clk);
        ib_valid = 1'b1;
        ib_data  = b;
        for (int k = 0; k < 400 && !acc; k++) begin
            acc = ib_ready;
            @(negedge clk);
        end
        ib_valid = 1'b0;
        ib_data  = 8'($urandom);
        if (!acc) chk("ib_timeout", 32'(ib_ready), 32'd1);
    endtask

    // Send an instruction and queue the microword sequence it must produce.
    task automatic send_insn(input bit wpre, input bit npre, input logic [7:0] opc,
                             input logic [31:0] ops_in, input bit rnd_ops);
        int          n;
        logic [31:0] ops;
        logic [7:0]  a;
        if (wpre) begin
            send_byte(8'hC4);
            mwide = 1'b1;
        end
        if (npre) send_byte(8'h00);
        n = int'(pc_rom[opc]) * (mwide ? 2 : 1);
        if (n > 4) begin
            exp_illegal++;
            send_byte(opc);
            chk("illegal_pulse", 32'(illegal), 32'd1);
            chk("illegal_no_valid", 32'(useq_valid), 32'd0);
            chk("illegal_cnt", 32'(opnd_count), 32'(n % 8));
            mwide = 1'b0;
            return;
        end
        ops = 32'h0;
        for (int i = 0; i < n; i++) begin
            ops[8*i +: 8] = rnd_ops ? 8'($urandom) : ops_in[8*i +: 8];
        end
        a = opc;
        do begin
            exp_q.push_back('{adr: a, opc: opc, cnt: n, ops: ops, wide: mwide, last: (nx_rom[a] == 8'h00)});
            a = nx_rom[a];
        end while (a != 8'h00);
        send_byte(opc);
        for (int i = 0; i < n; i++) begin
            chk("no_early_valid", 32'(useq_valid), 32'd0);
            send_byte(ops[8*i +: 8]);
        end
        chk("latency", 32'(useq_valid), 32'd1);
        mwide = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || useq_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: stability under stall, post-chain ready, and handshake scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_after) begin
                chk("ib_ready_after_chain", 32'(ib_ready), 32'd1);
                chk("valid_after_chain", 32'(useq_valid), 32'd0);
                chk_after = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_adr", 32'(useq_adr), 32'(prev_adr));
                chk("stall_valid", 32'(useq_valid), 32'd1);
            end
            if (illegal) seen_illegal++;
            if (useq_valid && force_stall > 0) begin
                useq_ready = 1'b0;
                force_stall--;
            end else begin
                useq_ready = 1'($urandom_range(0, 1));
            end
            prev_stall = useq_valid && !useq_ready;
            prev_adr   = useq_adr;
            if (useq_valid && useq_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_useq", 32'(useq_adr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("useq_adr", 32'(useq_adr), 32'(e.adr));
                    chk("jvm_opcode", 32'(jvm_opcode), 32'(e.opc));
                    chk("opnd_count", 32'(opnd_count), 32'(e.cnt));
                    chk("operands", operands, e.ops);
                    chk("is_wide", 32'(is_wide), 32'(e.wide));
                    chk("busy_iter", 32'(busy), 32'd1);
                    if (e.last) chk_after = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [7:0] opc;
        for (int a = 0; a < 256; a++) begin
            pc_rom[a] = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'($urandom_range(0, 3));
            nx_rom[a] = (a < 8'hF0 && $urandom_range(0, 2) != 0) ? 8'(a + $urandom_range(1, 16)) : 8'h00;
        end
        pc_rom[8'h10] = 3'd1; nx_rom[8'h10] = 8'h21; nx_rom[8'h21] = 8'h00;
        pc_rom[8'h15] = 3'd1;
        pc_rom[8'h33] = 3'd3;
        pc_rom[8'h77] = 3'd1;
        pc_rom[8'h60] = 3'd0; nx_rom[8'h60] = 8'h61; nx_rom[8'h61] = 8'h00;
        pc_rom[8'h30] = 3'd3;

        reset = 1'b0; ib_valid = 1'b0; ib_data = 8'h00; useq_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ib_ready", 32'(ib_ready), 32'd1);
        chk("rst_useq_valid", 32'(useq_valid), 32'd0);
        chk("rst_useq_adr", 32'(useq_adr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        send_insn(1'b0, 1'b0, 8'h10, 32'h7F, 1'b0);
        drain();
        send_insn(1'b1, 1'b1, 8'h15, 32'h0201, 1'b0);
        drain();
        send_insn(1'b1, 1'b0, 8'h33, 32'h0, 1'b0);
        send_insn(1'b0, 1'b0, 8'h77, 32'h5A, 1'b0);
        drain();
        force_stall = 5;
        send_insn(1'b0, 1'b0, 8'h60, 32'h0, 1'b0);
        drain();

        gap_en = 1'b1;
        for (int t = 0; t < 150; t++) begin
            do opc = 8'($urandom); while (opc == 8'hC4 || opc == 8'h00);
            send_insn($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, opc, 32'h0, 1'b1);
        end
        drain();
        gap_en = 1'b0;

        // Reset in the middle of operand collection discards the instruction.
        send_byte(8'h30);
        send_byte(8'hAA);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ib_ready", 32'(ib_ready), 32'd1);
        chk("mid_rst_useq_valid", 32'(useq_valid), 32'd0);
        chk("mid_rst_opcode", 32'(jvm_opcode), 32'd0);
        chk("mid_rst_operands", operands, 32'd0);
        chk("mid_rst_cnt", 32'(opnd_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        send_insn(1'b0, 1'b0, 8'h30, 32'h0033_2211, 1'b0);
        drain();

        chk("illegal_count", 32'(seen_illegal), 32'(exp_illegal));
        chk("idle_busy", 32'(busy), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
